// File: rtl/run_detect_arbiter.sv
// Four-way arbiter time-sharing one serial two-ones run detector; Mealy grant in IDLE, done NBITS+1 cycles after grant.
// Optional RUN_DETECT_RR_EN selects round-robin arbitration (fixed priority, requester 0 highest, otherwise).
module run_detect_arbiter #(
  parameter int NBITS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [3:0]       req,
  input  logic [NBITS-1:0] data0,
  input  logic [NBITS-1:0] data1,
  input  logic [NBITS-1:0] data2,
  input  logic [NBITS-1:0] data3,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [1:0]       id,
  output logic [1:0]       y
);
  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_t;
  typedef enum logic [1:0] {DET_A = 2'd0, DET_B = 2'd1, DET_C = 2'd2} det_t;

  state_t           state_q, state_d;
  det_t             det_q, det_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       win_idx;
  logic [NBITS-1:0] win_data;
  logic             grant_go;
  logic             last_bit;

  function automatic det_t det_next(input det_t s, input logic b);
    if (!b) return DET_A;
    if (s == DET_A) return DET_B;
    return DET_C;
  endfunction

`ifdef RUN_DETECT_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Scan from the largest offset down so the nearest requester after the last winner wins.
  always_comb begin
    win_idx = ptr_q + 2'd1;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i + 1)]) win_idx = ptr_q + 2'(i + 1);
    end
  end
`else
  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win_idx = 2'(i);
    end
  end
`endif

  always_comb begin
    win_data = data0;
    case (win_idx)
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      2'd3:    win_data = data3;
      default: win_data = data0;
    endcase
  end

  assign grant_go = (state_q == ST_IDLE) && (req != 4'b0000);
  assign last_bit = (cnt_q == CW'(NBITS - 1));

  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = grant_go ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_d = last_bit ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt  = (grant_go && Resetn) ? (4'b0001 << win_idx) : 4'b0000;
    busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
    hit  = done && sticky_q;
    id   = done ? id_q : 2'b00;
    y    = det_q;
  end

  always_comb begin
    sh_d     = sh_q;
    det_d    = det_q;
    sticky_d = sticky_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
`ifdef RUN_DETECT_RR_EN
    ptr_d    = ptr_q;
`endif
    if (grant_go) begin
      sh_d     = win_data;
      det_d    = DET_A;
      sticky_d = 1'b0;
      id_d     = win_idx;
      cnt_d    = '0;
`ifdef RUN_DETECT_RR_EN
      ptr_d    = win_idx;
`endif
    end else if (state_q == ST_SHIFT) begin
      sh_d  = sh_q >> 1;
      det_d = det_next(det_q, sh_q[0]);
      if (det_d == DET_C) sticky_d = 1'b1;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sh_q     <= '0;
      det_q    <= DET_A;
      sticky_q <= 1'b0;
      id_q     <= 2'b00;
      cnt_q    <= '0;
`ifdef RUN_DETECT_RR_EN
      ptr_q    <= 2'd3;
`endif
    end else begin
      sh_q     <= sh_d;
      det_q    <= det_d;
      sticky_q <= sticky_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
`ifdef RUN_DETECT_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_run_detect_arbiter.sv
// Directed and random jobs against a word-level model: hit = any adjacent pair of ones, y = clipped trailing-ones run.
module tb_run_detect_arbiter;
  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [NBITS-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]       gnt;
  logic             busy, done, hit;
  logic [1:0]       id, y;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = 3;

  run_detect_arbiter #(.NBITS(NBITS)) dut (
    .Clock(clk), .Resetn(rstn), .req(req),
    .data0(d0), .data1(d1), .data2(d2), .data3(d3),
    .gnt(gnt), .busy(busy), .done(done), .hit(hit), .id(id), .y(y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] r, input int p);
`ifdef RUN_DETECT_RR_EN
    for (int i = 1; i <= 4; i++) if (r[(p + i) % 4]) return 2'((p + i) % 4);
`else
    for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
`endif
    return 2'd0;
  endfunction

  function automatic logic [NBITS-1:0] word_of(input logic [1:0] w);
    case (w)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic exp_hit(input logic [NBITS-1:0] w);
    return |(w & (w >> 1));
  endfunction

  // Detector state after consuming the first n bits (LSB first): length of trailing ones run, clipped at 2.
  function automatic logic [1:0] exp_y(input logic [NBITS-1:0] w, input int n);
    int run = 0;
    for (int b = 0; b < n; b++) run = w[b] ? run + 1 : 0;
    return (run >= 2) ? 2'd2 : 2'(run);
  endfunction

  // Entered in an IDLE cycle with req/data driven; leaves in the IDLE cycle after done.
  task automatic do_job(input string tag, input logic [1:0] w,
                        input logic [3:0] busy_req, input logic [3:0] after_req);
    logic [NBITS-1:0] word;
    logic [3:0]       oh;
    word = word_of(w);
    oh   = 4'b0001 << w;
    #1;
    chk({tag, " gnt"}, gnt, oh);
    chk({tag, " idle busy"}, busy, 0);
    step();
    ptr = w;
    req = busy_req;
    for (int j = 0; j < NBITS; j++) begin
      chk({tag, " shift busy"}, busy, 1);
      chk({tag, " shift done"}, done, 0);
      chk({tag, " shift gnt"}, gnt, 0);
      chk({tag, " shift y"}, y, exp_y(word, j));
      step();
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " hit"}, hit, exp_hit(word));
    chk({tag, " id"}, id, w);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " done y"}, y, exp_y(word, NBITS));
    req = after_req;
    step();
    chk({tag, " post busy"}, busy, 0);
    chk({tag, " post done"}, done, 0);
    chk({tag, " post hit"}, hit, 0);
  endtask

  logic [1:0]       w;
  logic [3:0]       pend;
  logic [NBITS-1:0] pat [4];

  initial begin
    // reset state
    rstn = 1'b0;
    step();
    step();
    chk("rst gnt", gnt, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hit", hit, 0);
    chk("rst id", id, 0);
    chk("rst y", y, 0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold gnt", gnt, 0);
      chk("hold busy", busy, 0);
      chk("hold done", done, 0);
    end

    // first job: all ones on requester 0
    d0 = 8'hFF;
    req = 4'b0001;
    do_job("ff", pick(req, ptr), 4'b0000, 4'b0000);

    // single-job patterns on requester 1
    pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'h03; pat[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      d1 = pat[i];
      req = 4'b0010;
      do_job("pat", pick(req, ptr), 4'b0000, 4'b0000);
    end

    // back-to-back jobs, no carry-over between them
    d2 = 8'h01;
    req = 4'b0100;
    do_job("b2b1", pick(req, ptr), 4'b0000, 4'b0100);
    do_job("b2b2", pick(req, ptr), 4'b0000, 4'b0000);

    // all requesters held high
    d0 = 8'h06; d1 = 8'h11; d2 = 8'hE0; d3 = 8'h29;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_job("all", pick(req, ptr), 4'b1111, (i == 4) ? 4'b0011 : 4'b1111);

    // reset in the 4th shift cycle discards the job
    w = pick(req, ptr);
    #1;
    chk("mid gnt", gnt, 4'b0001 << w);
    step();
    for (int i = 0; i < 3; i++) step();
    chk("mid busy before rst", busy, 1);
    rstn = 1'b0;
    step();
    ptr = 3;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst gnt", gnt, 0);
    chk("mid rst y", y, 0);
    step();
    chk("mid rst done2", done, 0);
    rstn = 1'b1;
    do_job("after rst", pick(req, ptr), 4'b0000, 4'b0000);
    chk("after rst winner", w == 2'd0 ? 8'd1 : 8'd0, (pick(4'b0011, ptr) == w) ? 8'd1 : 8'd0);

    // request seen only while busy must never be granted
    d0 = 8'h33;
    req = 4'b0001;
    do_job("pulse", pick(req, ptr), 4'b0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      chk("pulse idle gnt", gnt, 0);
      chk("pulse idle busy", busy, 0);
      step();
    end

    // random jobs with pending requests carried over
    pend = 4'($urandom_range(1, 15));
    req = pend;
    for (int n = 0; n < 20; n++) begin
      d0 = NBITS'($urandom); d1 = NBITS'($urandom);
      d2 = NBITS'($urandom); d3 = NBITS'($urandom);
      w = pick(req, ptr);
      pend = req & ~(4'b0001 << w);
      begin
        logic [3:0] nxt;
        nxt = pend | 4'($urandom_range(0, 15));
        if (nxt == 4'b0000) nxt = 4'b0001 << $urandom_range(0, 3);
        do_job("rand", w, pend, nxt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
